fifo_uart_tx: RTL and testbench

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

---
 rtl/fifo_uart_tx.sv | 113 +++++++++++
 tb/tb_fifo_uart_tx.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pulls WIDTH-bit words from a FIFO with a registered read port.
// Each frame: REQ (read strobe), WAIT (data arrives), START, WIDTH data bits LSB first, STOP.
module fifo_uart_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tx_en,
  input  logic [WIDTH-1:0] fifo_data,
  input  logic             fifo_empty,
  output logic             fifo_r_en,
  output logic             tx,
  output logic             busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(WIDTH - 1);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, START, DATA, STOP} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] baud_q;
  logic [IDX_W-1:0] bit_idx_q;
  logic [WIDTH-1:0] shift_q;
  logic             tx_q;

  logic baud_done;
  logic start_ok;

  assign baud_done = (baud_q == BAUD_LAST);
  assign start_ok  = tx_en && !fifo_empty;

  // tx_q is always loaded on the edge that enters the state it belongs to,
  // so the line level lines up with the state register without a comb path.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          baud_q    <= '0;
          bit_idx_q <= '0;
          tx_q      <= 1'b1;
          if (start_ok) state_q <= REQ;
        end
        REQ: begin
          baud_q  <= '0;
          tx_q    <= 1'b1;
          state_q <= WAIT;
        end
        WAIT: begin
          shift_q <= fifo_data;
          baud_q  <= '0;
          tx_q    <= 1'b0;
          state_q <= START;
        end
        START: begin
          if (baud_done) begin
            baud_q    <= '0;
            bit_idx_q <= '0;
            tx_q      <= shift_q[0];
            shift_q   <= shift_q >> 1;
            state_q   <= DATA;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_q <= '0;
            if (bit_idx_q == IDX_LAST) begin
              bit_idx_q <= '0;
              tx_q      <= 1'b1;
              state_q   <= STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
              tx_q      <= shift_q[0];
              shift_q   <= shift_q >> 1;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        STOP: begin
          tx_q <= 1'b1;
          if (baud_done) begin
            baud_q  <= '0;
            state_q <= start_ok ? REQ : IDLE;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          baud_q  <= '0;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign fifo_r_en = (state_q == REQ);
  assign busy      = (state_q != IDLE);
  assign tx        = tx_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx (WIDTH=8, CLKS_PER_BIT=16) driving a 16-deep FIFO model.
// Frames are decoded from tx by sampling every cycle of a 160-cycle frame.
module tb_fifo_uart_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, tx_en, fifo_empty, fifo_r_en, tx, busy;
  logic [7:0] fifo_data;

  logic [7:0] mem [0:15];
  logic [3:0] wp, rp;
  logic [4:0] cnt;
  logic [7:0] fifo_q;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       fifo_clr;
  logic       glitch_en;
  logic       wait_flag;
  logic       do_rd, do_wr;

  int vectors = 0;
  int errors  = 0;
  int rpulses = 0;
  int viol    = 0;

  assign fifo_empty = (cnt == 5'd0);
  assign do_rd      = fifo_r_en && (cnt != 5'd0);
  assign do_wr      = wr_en && (cnt != 5'd16);
  // Outside the cycle after a read strobe, optionally present garbage to the DUT.
  assign fifo_data  = (glitch_en && !wait_flag) ? 8'hFF : fifo_q;

  always @(posedge clk) begin
    wait_flag <= fifo_r_en;
    if (fifo_r_en === 1'b1) rpulses <= rpulses + 1;
    if (fifo_r_en === 1'b1 && fifo_empty) viol <= viol + 1;
    if (fifo_clr) begin
      wp     <= '0;
      rp     <= '0;
      cnt    <= '0;
      fifo_q <= '0;
    end else begin
      if (do_wr) begin
        mem[wp] <= wr_data;
        wp      <= wp + 4'd1;
      end
      if (do_rd) begin
        fifo_q <= mem[rp];
        rp     <= rp + 4'd1;
      end
      cnt <= cnt + 5'(do_wr) - 5'(do_rd);
    end
  end

  fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_en      (tx_en),
    .fifo_data  (fifo_data),
    .fifo_empty (fifo_empty),
    .fifo_r_en  (fifo_r_en),
    .tx         (tx),
    .busy       (busy)
  );

  function automatic logic [7:0] val(input int i);
    return 8'(i * 37 + 11);
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  // Returns with the first start-bit cycle as the current cycle; waited = cycles skipped.
  task automatic wait_start(output int waited);
    waited = 0;
    while (tx !== 1'b0 && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    vectors++;
    if (tx !== 1'b0) begin
      errors++;
      $display("FAIL start_timeout: tx=%b after %0d cycles, required 0", tx, waited);
    end
  endtask

  // Captures one frame starting at the current cycle; ends on the last stop-bit cycle.
  task automatic rx_frame(input int drop_at, output logic [7:0] d, output logic ok);
    logic [9:0] bits;
    logic       stable;
    bits   = '0;
    stable = 1'b1;
    for (int c = 0; c < 160; c++) begin
      if (c == drop_at) tx_en = 1'b0;
      if (c % 16 == 0) bits[c/16] = tx;
      else if (tx !== bits[c/16]) stable = 1'b0;
      if (c < 159) @(negedge clk);
    end
    d  = bits[8:1];
    ok = stable && (bits[0] === 1'b0) && (bits[9] === 1'b1);
  endtask

  task automatic test_reset;
    reset = 1'b1; tx_en = 1'b0; wr_en = 1'b0; wr_data = '0;
    glitch_en = 1'b0; fifo_clr = 1'b1;
    cyc(2);
    vectors++;
    if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b, required 1", tx); end
    vectors++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
    vectors++;
    if (fifo_r_en !== 1'b0) begin errors++; $display("FAIL reset_r_en: got %b, required 0", fifo_r_en); end
    reset = 1'b0; fifo_clr = 1'b0;
    cyc(1);
    $display("test_reset done");
  endtask

  task automatic test_idle_empty;
    int p0, bad;
    tx_en = 1'b1;
    p0 = rpulses; bad = 0;
    for (int i = 0; i < 500; i++) begin
      cyc(1);
      if (tx !== 1'b1 || busy !== 1'b0 || fifo_r_en !== 1'b0) bad++;
    end
    vectors++;
    if (bad !== 0) begin errors++; $display("FAIL idle_empty_outputs: %0d bad cycles, required 0", bad); end
    vectors++;
    if (rpulses - p0 !== 0) begin errors++; $display("FAIL idle_empty_r_en: %0d pulses, required 0", rpulses - p0); end
    $display("test_idle_empty: %0d bad cycles", bad);
  endtask

  task automatic test_single;
    int p0, w;
    logic [7:0] d;
    logic ok;
    p0 = rpulses;
    push(8'hA5);
    wait_start(w);
    rx_frame(-1, d, ok);
    vectors++;
    if (d !== 8'hA5 || !ok) begin errors++; $display("FAIL single_frame: got %h ok=%b, required a5 ok=1", d, ok); end
    vectors++;
    if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_last_stop: got %b, required 1", busy); end
    cyc(1);
    vectors++;
    if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_after_160: got %b, required 0", busy); end
    vectors++;
    if (rpulses - p0 !== 1) begin errors++; $display("FAIL single_r_en_pulses: got %0d, required 1", rpulses - p0); end
    vectors++;
    if (fifo_empty !== 1'b1) begin errors++; $display("FAIL single_fifo_empty: got %b, required 1", fifo_empty); end
    $display("test_single: frame %h ok=%b", d, ok);
  endtask

  task automatic test_back_to_back;
    int p0, w;
    logic [7:0] d;
    logic ok;
    logic [7:0] exp [0:2];
    exp[0] = 8'h00; exp[1] = 8'hFF; exp[2] = 8'h55;
    p0 = rpulses;
    push(8'h00); push(8'hFF); push(8'h55);
    for (int k = 0; k < 3; k++) begin
      wait_start(w);
      if (k > 0) begin
        vectors++;
        if (w !== 2) begin errors++; $display("FAIL b2b_gap%0d: got %0d cycles, required 2", k, w); end
      end
      rx_frame(-1, d, ok);
      vectors++;
      if (d !== exp[k] || !ok) begin errors++; $display("FAIL b2b_frame%0d: got %h ok=%b, required %h ok=1", k, d, ok, exp[k]); end
      $display("test_back_to_back: frame %0d = %h gap %0d", k, d, w);
      cyc(1);
    end
    vectors++;
    if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_end: got %b, required 0", busy); end
    vectors++;
    if (rpulses - p0 !== 3) begin errors++; $display("FAIL b2b_r_en_pulses: got %0d, required 3", rpulses - p0); end
  endtask

  task automatic test_txen_drop;
    int p0, w, bad;
    logic [7:0] d;
    logic ok;
    tx_en = 1'b0;
    cyc(2);
    p0 = rpulses;
    for (int i = 0; i < 16; i++) push(val(i));
    vectors++;
    if (cnt !== 5'd16) begin errors++; $display("FAIL drop_fill: fifo count %0d, required 16", cnt); end
    tx_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wait_start(w);
      rx_frame(i == 1 ? 85 : -1, d, ok);
      vectors++;
      if (d !== val(i) || !ok) begin errors++; $display("FAIL drop_frame%0d: got %h ok=%b, required %h ok=1", i, d, ok, val(i)); end
      $display("test_txen_drop: frame %0d = %h", i, d);
      cyc(1);
    end
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      if (busy !== 1'b0 || tx !== 1'b1) bad++;
      cyc(1);
    end
    vectors++;
    if (bad !== 0) begin errors++; $display("FAIL drop_idle: %0d busy/tx bad cycles, required 0", bad); end
    vectors++;
    if (cnt !== 5'd14) begin errors++; $display("FAIL drop_remaining: fifo count %0d, required 14", cnt); end
    tx_en = 1'b1;
    for (int i = 2; i < 16; i++) begin
      wait_start(w);
      if (i > 2) begin
        vectors++;
        if (w !== 2) begin errors++; $display("FAIL drop_gap%0d: got %0d cycles, required 2", i, w); end
      end
      rx_frame(-1, d, ok);
      vectors++;
      if (d !== val(i) || !ok) begin errors++; $display("FAIL drop_frame%0d: got %h ok=%b, required %h ok=1", i, d, ok, val(i)); end
      $display("test_txen_drop: frame %0d = %h", i, d);
      cyc(1);
    end
    vectors++;
    if (rpulses - p0 !== 16) begin errors++; $display("FAIL drop_r_en_pulses: got %0d, required 16", rpulses - p0); end
    vectors++;
    if (fifo_empty !== 1'b1) begin errors++; $display("FAIL drop_fifo_empty: got %b, required 1", fifo_empty); end
  endtask

  task automatic test_reset_midframe;
    int p0, w, bad;
    logic [7:0] d;
    logic ok;
    tx_en = 1'b0;
    cyc(2);
    p0 = rpulses;
    push(8'h3C); push(8'h81);
    tx_en = 1'b1;
    wait_start(w);
    cyc(69);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    vectors++;
    if (tx !== 1'b1) begin errors++; $display("FAIL midreset_tx: got %b, required 1", tx); end
    vectors++;
    if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b, required 0", busy); end
    wait_start(w);
    rx_frame(-1, d, ok);
    vectors++;
    if (d !== 8'h81 || !ok) begin errors++; $display("FAIL midreset_frame: got %h ok=%b, required 81 ok=1", d, ok); end
    $display("test_reset_midframe: frame after reset = %h", d);
    cyc(1);
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      if (tx !== 1'b1) bad++;
      cyc(1);
    end
    vectors++;
    if (bad !== 0) begin errors++; $display("FAIL midreset_no_resend: %0d low cycles, required 0", bad); end
    vectors++;
    if (rpulses - p0 !== 2) begin errors++; $display("FAIL midreset_r_en_pulses: got %0d, required 2", rpulses - p0); end
  endtask

  task automatic test_data_glitch;
    int p0, w;
    logic [7:0] d;
    logic ok;
    glitch_en = 1'b1;
    p0 = rpulses;
    push(8'h12);
    wait_start(w);
    rx_frame(-1, d, ok);
    glitch_en = 1'b0;
    vectors++;
    if (d !== 8'h12 || !ok) begin errors++; $display("FAIL glitch_frame: got %h ok=%b, required 12 ok=1", d, ok); end
    cyc(1);
    vectors++;
    if (rpulses - p0 !== 1) begin errors++; $display("FAIL glitch_r_en_pulses: got %0d, required 1", rpulses - p0); end
    vectors++;
    if (viol !== 0) begin errors++; $display("FAIL r_en_while_empty: %0d occurrences, required 0", viol); end
    $display("test_data_glitch: frame %h", d);
  endtask

  initial begin
    test_reset();
    test_idle_empty();
    test_single();
    test_back_to_back();
    test_txen_drop();
    test_reset_midframe();
    test_data_glitch();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
